// File: rtl/ws2812_pkg.sv
// WS2812 chain driver: shared state encoding and timing helpers.
// Cycle counts are rounded to the nearest clock period.
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_e;

    function automatic longint n_cycles(longint clk_fre, longint t_ns);
        return (clk_fre / 1000 * t_ns + 500000) / 1000000;
    endfunction

    // The wire order is G, R, B with each byte MSB first.
    function automatic logic [23:0] to_grb(logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel buffer: one write port, one registered read port.
// Contents survive reset; only the read register is cleared.
module ws2812_pixel_ram #(
    parameter int NUM_LEDS = 8,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [23:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [23:0]   rdata_o
);

    localparam logic [AW:0] DEPTH = (AW+1)'(NUM_LEDS);

    logic [23:0] mem_q [NUM_LEDS];
    logic [23:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i && ({1'b0, waddr_i} < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ws2812_chain.sv
// WS2812 serial driver: frames the pixel buffer onto one data line,
// GRB order, MSB first, followed by a low latch period.
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int CLK_FRE      = 27_000_000,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 850,
    parameter int TBIT_NS      = 1250,
    parameter int RESET_US     = 80,
    parameter int AUTO_REFRESH = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  logic [$clog2(NUM_LEDS > 1 ? NUM_LEDS : 2)-1:0] wr_addr,
    input  logic [23:0] wr_rgb,
    input  logic start,
    output logic busy,
    output logic done,
    output logic dout
);

    localparam int AW   = $clog2(NUM_LEDS > 1 ? NUM_LEDS : 2);
    localparam int T0H  = int'(n_cycles(CLK_FRE, T0H_NS));
    localparam int T1H  = int'(n_cycles(CLK_FRE, T1H_NS));
    localparam int TBIT = int'(n_cycles(CLK_FRE, TBIT_NS));
    localparam int T0L  = TBIT - T0H;
    localparam int T1L  = TBIT - T1H;
    localparam int TRST = int'(n_cycles(CLK_FRE, longint'(RESET_US) * 1000));
    localparam int CW   = $clog2((TRST > TBIT ? TRST : TBIT) + 1);

    localparam logic [CW-1:0] C_T0H    = CW'(T0H - 1);
    localparam logic [CW-1:0] C_T1H    = CW'(T1H - 1);
    localparam logic [CW-1:0] C_T0L    = CW'(T0L - 1);
    localparam logic [CW-1:0] C_T1L    = CW'(T1L - 1);
    localparam logic [CW-1:0] C_T0L_LD = CW'(T0L - 2);
    localparam logic [CW-1:0] C_T1L_LD = CW'(T1L - 2);
    localparam logic [CW-1:0] C_TRST   = CW'(TRST - 1);
    localparam logic [AW-1:0] LAST_LED = AW'(NUM_LEDS - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    bit_q;
    logic [AW-1:0] led_q;
    logic [23:0]   shift_q;
    logic          dout_q;
    logic          busy_q;
    logic          done_q;

    logic          go_d;
    logic          boundary_d;
    logic          rd_en_d;
    logic [AW-1:0] rd_addr_d;
    logic [23:0]   rd_data;
    logic [23:0]   load_grb_d;
    logic [CW-1:0] low_cnt_d;

    ws2812_pixel_ram #(
        .NUM_LEDS(NUM_LEDS),
        .AW      (AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (wr_en),
        .waddr_i(wr_addr),
        .wdata_i(wr_rgb),
        .re_i   (rd_en_d),
        .raddr_i(rd_addr_d),
        .rdata_o(rd_data)
    );

    // Next LED's pixel is fetched in the last low cycle so LOAD sees it.
    always_comb begin
        go_d       = (state_q == ST_IDLE) && (start || (AUTO_REFRESH != 0));
        boundary_d = (bit_q == '0) && (led_q != LAST_LED);
        rd_en_d    = go_d
                   || ((state_q == ST_LOW) && (cnt_q == '0) && boundary_d);
        rd_addr_d  = go_d ? '0 : led_q + AW'(1);
        load_grb_d = to_grb(rd_data);
        if (shift_q[23]) begin
            low_cnt_d = boundary_d ? C_T1L_LD : C_T1L;
        end else begin
            low_cnt_d = boundary_d ? C_T0L_LD : C_T0L;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            led_q   <= '0;
            shift_q <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    dout_q <= 1'b0;
                    if (go_d) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        led_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    shift_q <= load_grb_d;
                    bit_q   <= 5'd23;
                    cnt_q   <= load_grb_d[23] ? C_T1H : C_T0H;
                    dout_q  <= 1'b1;
                    state_q <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        dout_q  <= 1'b0;
                        cnt_q   <= low_cnt_d;
                        state_q <= ST_LOW;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (bit_q != '0) begin
                        bit_q   <= bit_q - 5'd1;
                        shift_q <= {shift_q[22:0], 1'b0};
                        cnt_q   <= shift_q[22] ? C_T1H : C_T0H;
                        dout_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end else if (led_q == LAST_LED) begin
                        cnt_q   <= C_TRST;
                        state_q <= ST_LATCH;
                    end else begin
                        led_q   <= led_q + AW'(1);
                        state_q <= ST_LOAD;
                    end
                end
                ST_LATCH: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
